piso_serializer: RTL and testbench

//   Launch side of the team's flip-flop data path: accepts a parallel word over a

---
 rtl/piso_serializer.sv | 124 ++++++++++++
 tb/tb_piso_serializer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out launcher: takes a word over valid/ready and shifts it out
// one bit per clock with framing strobes; back-to-back words leave no idle gap.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_out_n,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W   = $clog2(WIDTH);
  localparam int unsigned OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             ser_q, ser_d;
  logic             ser_n_q, ser_n_d;
  logic             valid_q, valid_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             accept;

  assign accept = in_valid && ready_q;

  // State, datapath and registered strobes; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      ser_q   <= 1'b0;
      ser_n_q <= 1'b1;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      ser_q   <= ser_d;
      ser_n_q <= ser_n_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; outputs are decoded from the next state so they land registered.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          shreg_d = in_data;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (accept) begin
            shreg_d = in_data;
          end else begin
            state_d = S_IDLE;
            shreg_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d = (state_d == S_SHIFT);
    busy_d  = valid_d;
    ser_d   = valid_d && shreg_d[OUT_IDX];
    ser_n_d = !ser_d;
    frame_d = valid_d && (cnt_d == '0);
    done_d  = valid_d && (cnt_d == LAST_CNT);
    ready_d = !valid_d || (cnt_d == LAST_CNT);
  end

  assign in_ready    = ready_q;
  assign ser_out     = ser_q;
  assign ser_out_n   = ser_n_q;
  assign ser_valid   = valid_q;
  assign frame_start = frame_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first instance checked through a bit scoreboard,
// plus an LSB-first instance for bit-order checks.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] a_in_data, b_in_data;
  logic       a_in_valid, b_in_valid;
  logic       a_in_ready, a_ser_out, a_ser_out_n, a_ser_valid, a_frame, a_done, a_busy;
  logic       b_in_ready, b_ser_out, b_ser_out_n, b_ser_valid, b_frame, b_done, b_busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int valid_run = 0;
  int last_run  = 0;

  // expected {ser_out, ser_out_n, frame_start, done} per live bit
  logic [3:0] exp_q[$];
  logic [3:0] exp_b[$];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .ser_out(a_ser_out), .ser_out_n(a_ser_out_n),
    .ser_valid(a_ser_valid), .frame_start(a_frame), .done(a_done), .busy(a_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .ser_out(b_ser_out), .ser_out_n(b_ser_out_n),
    .ser_valid(b_ser_valid), .frame_start(b_frame), .done(b_done), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard for instance A: every live bit pops one expectation; idle cycles must be quiet.
  always @(negedge clk) begin
    logic [3:0] exp_v;
    if (!rst) begin
      valid_run = 0;
    end else if (a_ser_valid) begin
      valid_run++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_bit: got ser=%b frame=%b done=%b with no word pending",
                 a_ser_out, a_frame, a_done);
      end else begin
        exp_v = exp_q.pop_front();
        if ({a_ser_out, a_ser_out_n, a_frame, a_done} !== exp_v)
          $display("FAIL serial_bit: got {ser,ser_n,frame,done}=%b want %b",
                   {a_ser_out, a_ser_out_n, a_frame, a_done}, exp_v);
        else
          pass_cnt++;
      end
    end else begin
      if (valid_run != 0) begin
        last_run  = valid_run;
        valid_run = 0;
      end
      chk_cnt++;
      if ({a_ser_out, a_ser_out_n, a_frame, a_done, a_busy} !== 5'b01000)
        $display("FAIL idle_outputs: got {ser,ser_n,frame,done,busy}=%b want 01000",
                 {a_ser_out, a_ser_out_n, a_frame, a_done, a_busy});
      else
        pass_cnt++;
    end
  end

  // Presents a word on instance A (caller is at a falling edge), queues its bits,
  // and returns at the falling edge after acceptance with in_valid dropped.
  task automatic send_word(input logic [7:0] d);
    int waited = 0;
    a_in_data  = d;
    a_in_valid = 1'b1;
    for (int i = 0; i < 8; i++)
      exp_q.push_back({d[7-i], ~d[7-i], (i == 0), (i == 7)});
    while (!a_in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      chk_cnt++;
      $display("FAIL accept_timeout: in_ready stayed %b, want 1", a_in_ready);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    a_in_data  = '0;
    b_in_data  = '0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({a_in_ready, a_ser_out, a_ser_out_n, a_ser_valid, a_frame, a_done, a_busy} !== 7'b0010000)
      $display("FAIL reset_state: got {rdy,ser,ser_n,val,frame,done,busy}=%b want 0010000",
               {a_in_ready, a_ser_out, a_ser_out_n, a_ser_valid, a_frame, a_done, a_busy});
    else
      pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
      $display("FAIL ready_after_reset: got a=%b b=%b want 1", a_in_ready, b_in_ready);
    else
      pass_cnt++;
  endtask

  task automatic test_single_word();
    send_word(8'hA5);
    for (int i = 0; i < 30 && (exp_q.size() != 0 || a_ser_valid); i++) @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0 || last_run != 8)
      $display("FAIL single_word: got pending=%0d run=%0d want pending=0 run=8",
               exp_q.size(), last_run);
    else
      pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send_word(8'hA5);
    send_word(8'h3C);
    for (int i = 0; i < 40 && (exp_q.size() != 0 || a_ser_valid); i++) @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0 || last_run != 16)
      $display("FAIL back_to_back: got pending=%0d run=%0d want pending=0 run=16",
               exp_q.size(), last_run);
    else
      pass_cnt++;
  endtask

  task automatic test_ignore_unready();
    send_word(8'h00);
    repeat (3) @(negedge clk);
    a_in_data  = 8'hFF;
    a_in_valid = 1'b1;
    chk_cnt++;
    if (a_in_ready !== 1'b0)
      $display("FAIL ready_mid_word: got %b want 0", a_in_ready);
    else
      pass_cnt++;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 30 && (exp_q.size() != 0 || a_ser_valid); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0 || last_run != 8 || a_ser_valid !== 1'b0)
      $display("FAIL ignore_unready: got pending=%0d run=%0d valid=%b want 0/8/0",
               exp_q.size(), last_run, a_ser_valid);
    else
      pass_cnt++;
  endtask

  task automatic test_reset_abort();
    send_word(8'hF0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_cnt++;
    if ({a_ser_out, a_ser_out_n, a_ser_valid, a_busy, a_done, a_in_ready} !== 6'b010000)
      $display("FAIL reset_abort: got {ser,ser_n,val,busy,done,rdy}=%b want 010000",
               {a_ser_out, a_ser_out_n, a_ser_valid, a_busy, a_done, a_in_ready});
    else
      pass_cnt++;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (a_in_ready !== 1'b1 || a_ser_valid !== 1'b0 || a_done !== 1'b0)
      $display("FAIL abort_recover: got rdy=%b val=%b done=%b want 1/0/0",
               a_in_ready, a_ser_valid, a_done);
    else
      pass_cnt++;
  endtask

  task automatic test_lsb_first();
    logic [7:0] d;
    logic [3:0] exp_v;
    int waited = 0;
    d = 8'h01;
    b_in_data  = d;
    b_in_valid = 1'b1;
    for (int i = 0; i < 8; i++)
      exp_b.push_back({d[i], ~d[i], (i == 0), (i == 7)});
    while (!b_in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_v = exp_b.pop_front();
      chk_cnt++;
      if ({b_ser_valid, b_ser_out, b_ser_out_n, b_frame, b_done} !== {1'b1, exp_v})
        $display("FAIL lsb_bit%0d: got {val,ser,ser_n,frame,done}=%b want %b",
                 i, {b_ser_valid, b_ser_out, b_ser_out_n, b_frame, b_done}, {1'b1, exp_v});
      else
        pass_cnt++;
      @(negedge clk);
    end
    chk_cnt++;
    if ({b_ser_valid, b_ser_out, b_ser_out_n} !== 3'b001)
      $display("FAIL lsb_idle: got {val,ser,ser_n}=%b want 001",
               {b_ser_valid, b_ser_out, b_ser_out_n});
    else
      pass_cnt++;
  endtask

  task automatic test_idle_hold();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk_cnt++;
      if ({a_ser_valid, a_busy, a_in_ready} !== 3'b001)
        $display("FAIL idle_hold%0d: got {val,busy,rdy}=%b want 001",
                 i, {a_ser_valid, a_busy, a_in_ready});
      else
        pass_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_ignore_unready();
    test_reset_abort();
    test_lsb_first();
    test_idle_hold();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
